// File: rtl/tanh_arbiter_pkg.sv
// Shared LSTM tanh definitions: operand/result packets, tanh pipeline depth and the
// ownership tag that travels alongside each operation.
`ifndef LSTM_INPUT_BITS
`define LSTM_INPUT_BITS 16
`endif
`ifndef NUM_LSTM_MULT_STAGE
`define NUM_LSTM_MULT_STAGE 3
`endif

package tanh_arbiter_pkg;

  localparam int unsigned LSTM_DATA_BITS   = `LSTM_INPUT_BITS;
  // tanh unit = input register + multiplier stages + output register
  localparam int unsigned TANH_LATENCY     = `NUM_LSTM_MULT_STAGE + 2;
  localparam int unsigned TANH_NUM_REQ     = 4;
  localparam int unsigned TANH_TAG_ID_BITS = $clog2(TANH_NUM_REQ);

  typedef struct packed {
    logic [LSTM_DATA_BITS-1:0] data;
  } tanh_input_packet_t;

  typedef struct packed {
    logic [LSTM_DATA_BITS-1:0] data;
  } tanh_output_packet_t;

  typedef struct packed {
    logic                        valid;
    logic [TANH_TAG_ID_BITS-1:0] id;
  } tanh_tag_t;

endpackage

// File: rtl/tanh_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester after the pointer,
// wrapping modulo NUM_REQ.
module tanh_arbiter_rr #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] index_c,
  output logic                       found_c
);

  localparam int unsigned IDX_BITS = $clog2(NUM_REQ);

  logic [IDX_BITS-1:0] cand;

  always_comb begin
    grant_c = '0;
    index_c = '0;
    found_c = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_BITS'((32'(pointer) + k) % NUM_REQ);
      if (!found_c && eligible[cand]) begin
        found_c       = 1'b1;
        index_c       = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tanh_arbiter.sv
// Shares one fixed-latency tanh unit among NUM_REQ requesters: round-robin issue,
// tag shift register tracking ownership, per-requester outstanding limit.
module tanh_arbiter
  import tanh_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = TANH_NUM_REQ,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DATA_BITS       = LSTM_DATA_BITS
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]             req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  output tanh_input_packet_t                            tanh_packet_in,
  input  tanh_output_packet_t                           tanh_packet_out,
  output logic [NUM_REQ-1:0]                            resp_valid,
  output logic [DATA_BITS-1:0]                          resp_data,
  output logic [$clog2(NUM_REQ*MAX_OUTSTANDING+1)-1:0]  inflight,
  output logic                                          busy
);

  localparam int unsigned IDX_BITS      = $clog2(NUM_REQ);
  localparam int unsigned CNT_BITS      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned INFLIGHT_BITS = $clog2(NUM_REQ * MAX_OUTSTANDING + 1);

  logic [IDX_BITS-1:0]              pointer;
  logic [NUM_REQ-1:0][CNT_BITS-1:0] cnt;
  logic [NUM_REQ-1:0]               eligible;
  logic [NUM_REQ-1:0]               grant;
  logic [IDX_BITS-1:0]              grant_index;
  logic                             transfer;
  tanh_tag_t                        issue;
  tanh_tag_t [TANH_LATENCY-1:0]     tag_pipe;
  tanh_tag_t                        tag_exit;
  logic [NUM_REQ-1:0]               resp_hit;
  logic [INFLIGHT_BITS-1:0]         inflight_next;

  // Reset is folded in so no grant is ever shown while the block is held in reset.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = reset && enable && req_valid[i] &&
                    (32'(cnt[i]) < MAX_OUTSTANDING);
    end
  end

  tanh_arbiter_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .eligible (eligible),
    .pointer  (pointer),
    .grant_c  (grant),
    .index_c  (grant_index),
    .found_c  (transfer)
  );

  assign req_ready = grant;

  // Issue stage: winning operand and its owner, one per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pointer        <= IDX_BITS'(NUM_REQ - 1);
      issue          <= '0;
      tanh_packet_in <= '0;
    end else begin
      issue.valid <= transfer;
      if (transfer) begin
        pointer             <= grant_index;
        issue.id            <= TANH_TAG_ID_BITS'(grant_index);
        tanh_packet_in.data <= LSTM_DATA_BITS'(req_data[grant_index]);
      end
    end
  end

  // Tag pipe mirrors the tanh latency so its exit lines up with tanh_packet_out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= issue;
      for (int unsigned i = 1; i < TANH_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_exit = tag_pipe[TANH_LATENCY-1];

  always_comb begin
    resp_hit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_hit[i] = tag_exit.valid && (32'(tag_exit.id) == i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= resp_hit;
      if (tag_exit.valid) begin
        resp_data <= DATA_BITS'(tanh_packet_out.data);
      end
    end
  end

  // Outstanding count per requester; release happens on the edge the response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        case ({grant[i], resp_hit[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_BITS'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_BITS'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Running total of valid bits in the issue stage and tag pipe.
  assign inflight_next = inflight + INFLIGHT_BITS'(transfer)
                                  - INFLIGHT_BITS'(tag_exit.valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      busy     <= 1'b0;
    end else begin
      inflight <= inflight_next;
      busy     <= (inflight_next != '0);
    end
  end

endmodule

// File: tb/tb_tanh_arbiter.sv
// Directed bench for tanh_arbiter with a behavioural tanh pipe, a round-robin
// reference model and a scoreboard of expected responses.
module tb_tanh_arbiter;
  import tanh_arbiter_pkg::*;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned MAX_OUT  = 4;
  localparam int unsigned DW       = 16;
  localparam int unsigned RESP_LAT = TANH_LATENCY + 2;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         enable;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0][DW-1:0]   req_data;
  logic [NUM_REQ-1:0]           req_ready;
  tanh_input_packet_t           tanh_packet_in;
  tanh_output_packet_t          tanh_packet_out;
  logic [NUM_REQ-1:0]           resp_valid;
  logic [DW-1:0]                resp_data;
  logic [$clog2(NUM_REQ*MAX_OUT+1)-1:0] inflight;
  logic                         busy;

  always #5 clock = ~clock;

  tanh_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .MAX_OUTSTANDING (MAX_OUT),
    .DATA_BITS       (DW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .tanh_packet_in  (tanh_packet_in),
    .tanh_packet_out (tanh_packet_out),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .inflight        (inflight),
    .busy            (busy)
  );

  // Q8.8 hard tanh: clamp to +/-1.0
  function automatic logic [DW-1:0] hard_tanh(input logic [DW-1:0] d);
    logic signed [DW-1:0] s;
    s = d;
    if (s > 16'sh0100) return 16'h0100;
    if (s < -16'sh0100) return 16'hFF00;
    return d;
  endfunction

  // Behavioural tanh unit: not reset, so stale values keep flowing after a reset.
  logic [DW-1:0] tpipe [TANH_LATENCY];
  always @(posedge clock) begin
    tpipe[0] <= hard_tanh(tanh_packet_in.data);
    for (int i = 1; i < int'(TANH_LATENCY); i++) tpipe[i] <= tpipe[i-1];
  end
  assign tanh_packet_out = tpipe[TANH_LATENCY-1];

  typedef struct {
    int unsigned   id;
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t               sb[$];
  int                 errors = 0;
  int                 checks = 0;
  int unsigned        cyc = 0;
  int unsigned        ptr_m;
  int unsigned        cnt_m [NUM_REQ];
  int unsigned        accepted;
  int unsigned        resp_seen;
  logic [DW-1:0]      last_rd;
  logic               pkt_pending;
  logic [DW-1:0]      pkt_exp;
  logic [NUM_REQ-1:0] acc_last;
  int                 n_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    ptr_m       = NUM_REQ - 1;
    for (int i = 0; i < int'(NUM_REQ); i++) cnt_m[i] = 0;
    accepted    = 0;
    resp_seen   = 0;
    last_rd     = '0;
    pkt_pending = 1'b0;
    acc_last    = '0;
  endtask

  // One clock: sample at negedge, compare against the model, advance to posedge+1.
  task automatic run_cycle();
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rv;
    int unsigned        exp_inf;
    exp_t               e;
    @(negedge clock);
    exp_rv = '0;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_rv[e.id] = 1'b1;
      last_rd = e.data;
      cnt_m[e.id]--;
      resp_seen++;
    end
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("resp_data", 32'(resp_data), 32'(last_rd));
    exp_inf = accepted - resp_seen;
    check("inflight", 32'(inflight), exp_inf);
    check("busy", 32'(busy), 32'(exp_inf != 0));
    if (pkt_pending) check("tanh_packet_in", 32'(tanh_packet_in.data), 32'(pkt_exp));
    exp_ready = '0;
    if (reset && enable) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        if (exp_ready == '0 && req_valid[(ptr_m + k) % NUM_REQ] &&
            cnt_m[(ptr_m + k) % NUM_REQ] < MAX_OUT)
          exp_ready[(ptr_m + k) % NUM_REQ] = 1'b1;
      end
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    pkt_pending = 1'b0;
    acc_last = req_valid & exp_ready;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (acc_last[i]) begin
        sb.push_back('{id: i, data: hard_tanh(req_data[i]), due: cyc + RESP_LAT});
        cnt_m[i]++;
        ptr_m = i;
        accepted++;
        pkt_pending = 1'b1;
        pkt_exp = req_data[i];
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      run_cycle();
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    run_cycle();
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_packet_in", 32'(tanh_packet_in.data), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    enable    = 1'b1;
    req_valid = 4'hF;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Mixed data: req 0 first (pointer starts at 3), then req 3.
    req_data[0] = 16'h0400;
    req_data[3] = 16'hFC00;
    req_valid   = 4'b1001;
    repeat (2) begin
      run_cycle();
      req_valid &= ~acc_last;
    end
    drain(20);

    // All requesters valid continuously.
    req_data  = {4{16'hFC00}};
    req_valid = 4'hF;
    repeat (16) run_cycle();
    req_valid = '0;
    drain(20);

    // Single request.
    req_data[1] = 16'h0400;
    req_valid   = 4'b0010;
    run_cycle();
    req_valid &= ~acc_last;
    drain(20);

    // Outstanding limit on one requester, fresh data every cycle.
    req_valid = 4'b0100;
    for (int n = 0; n < 14; n++) begin
      req_data[2] = 16'h0020 + 16'(n * 16);
      run_cycle();
    end
    req_valid = '0;
    drain(20);

    // Drop enable after three accepts; those three still return.
    req_data[1] = 16'hFF80;
    req_valid   = 4'b0010;
    n_acc = 0;
    for (int n = 0; n < 10 && n_acc < 3; n++) begin
      run_cycle();
      if (acc_last[1]) n_acc++;
    end
    enable = 1'b0;
    drain(20);
    enable    = 1'b1;
    req_valid = '0;

    // Reset with five operations in flight.
    req_data  = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    req_valid = 4'hF;
    repeat (5) run_cycle();
    check("pre_reset_inflight", 32'(inflight), 32'd5);
    reset = 1'b0;
    #1;
    check("async_req_ready", 32'(req_ready), 32'd0);
    check("async_resp_valid", 32'(resp_valid), 32'd0);
    check("async_resp_data", 32'(resp_data), 32'd0);
    check("async_packet_in", 32'(tanh_packet_in.data), 32'd0);
    check("async_inflight", 32'(inflight), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    req_valid = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    repeat (12) run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
